// File: rtl/interrupt_controller.sv
// Prioritised, maskable interrupt controller with a memory-mapped register block on the
// dMemIO bus; one interrupt is held in service at a time until software writes EOI.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ       = 8,
    parameter logic [15:0] BASE_ADDR     = 16'h1080,
    parameter logic [15:0] VECTOR_BASE   = 16'h0008,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [15:0]        io_addr,
    input  logic [7:0]         io_wdata,
    input  logic               io_we,
    input  logic               io_re,
    output logic [7:0]         io_rdata,
    output logic               irq_req,
    input  logic               irq_ack,
    output logic [15:0]        interrupt_vector
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned VEC_W  = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SVC  = 2'd2;

    localparam logic [2:0] OFF_ENABLE  = 3'd0;
    localparam logic [2:0] OFF_PENDING = 3'd1;
    localparam logic [2:0] OFF_MODE    = 3'd2;
    localparam logic [2:0] OFF_ACTIVE  = 3'd3;
    localparam logic [2:0] OFF_EOI     = 3'd4;

    logic [NUM_IRQ-1:0] syncMeta;
    logic [NUM_IRQ-1:0] syncS;
    logic [NUM_IRQ-1:0] syncSd;
    logic [NUM_IRQ-1:0] enableReg;
    logic [NUM_IRQ-1:0] modeReg;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pendingNext;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] edgeSet;
    logic [NUM_IRQ-1:0] edgeClear;
    logic [NUM_IRQ-1:0] ackClear;
    logic [NUM_IRQ-1:0] wdataBits;

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic [ID_W-1:0]    id;
    logic [ID_W-1:0]    idNext;
    logic [ID_W-1:0]    winner;
    logic               candAny;
    logic               candAtId;
    logic               ackTake;
    logic               irqReqNext;
    logic [VEC_W-1:0]   vectorNext;
    logic               inService;

    logic               blockSel;
    logic [2:0]         regOffset;
    logic               wrEnable;
    logic               wrPending;
    logic               wrMode;
    logic               wrEoi;
    logic               rdSel;
    logic [DATA_W-1:0]  readData;

    assign blockSel  = (io_addr[15:3] == BASE_ADDR[15:3]);
    assign regOffset = io_addr[2:0];
    assign wrEnable  = blockSel && io_we && (regOffset == OFF_ENABLE);
    assign wrPending = blockSel && io_we && (regOffset == OFF_PENDING);
    assign wrMode    = blockSel && io_we && (regOffset == OFF_MODE);
    assign wrEoi     = blockSel && io_we && (regOffset == OFF_EOI);
    assign rdSel     = blockSel && io_re;
    assign wdataBits = io_wdata[NUM_IRQ-1:0];
    assign inService = (state == SVC);
    assign cand      = pending & enableReg;
    assign edgeSet   = syncS & ~syncSd;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta <= '0;
            syncS    <= '0;
            syncSd   <= '0;
        end else begin
            syncMeta <= irq_in;
            syncS    <= syncMeta;
            syncSd   <= syncS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enableReg <= '0;
            modeReg   <= '0;
        end else begin
            if (wrEnable) enableReg <= wdataBits;
            if (wrMode)   modeReg   <= wdataBits;
        end
    end

    // Edge sources: set beats clear. Level sources simply track the synchronised line.
    always_comb begin
        ackClear = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ackClear[i] = ackTake && (id == ID_W'(i));
        end
        edgeClear   = (wrPending ? wdataBits : '0) | ackClear;
        pendingNext = (modeReg & (edgeSet | (pending & ~edgeClear))) | (~modeReg & syncS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pendingNext;
    end

    // Lowest set index wins; candAtId tracks whether the latched request is still live
    always_comb begin
        winner   = '0;
        candAtId = 1'b0;
        candAny  = |cand;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) winner = ID_W'(i);
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (id == ID_W'(i)) candAtId = cand[i];
        end
    end

    always_comb begin
        stateNext  = state;
        idNext     = id;
        irqReqNext = irq_req;
        vectorNext = interrupt_vector;
        ackTake    = 1'b0;
        case (state)
            IDLE: begin
                if (candAny) begin
                    stateNext  = REQ;
                    idNext     = winner;
                    irqReqNext = 1'b1;
                    vectorNext = VEC_W'(VECTOR_BASE + VEC_W'(winner) * VECTOR_STRIDE);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    stateNext  = SVC;
                    irqReqNext = 1'b0;
                    ackTake    = 1'b1;
                end else if (!candAtId) begin
                    stateNext  = IDLE;
                    irqReqNext = 1'b0;
                end
            end
            SVC: begin
                if (wrEoi) stateNext = IDLE;
            end
            default: begin
                stateNext  = IDLE;
                irqReqNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            id               <= '0;
            irq_req          <= 1'b0;
            interrupt_vector <= VECTOR_BASE;
        end else begin
            state            <= stateNext;
            id               <= idNext;
            irq_req          <= irqReqNext;
            interrupt_vector <= vectorNext;
        end
    end

    // Unselected reads return zero so the result can be OR-merged onto the shared bus
    always_comb begin
        readData = '0;
        case (regOffset)
            OFF_ENABLE:  readData = DATA_W'(enableReg);
            OFF_PENDING: readData = DATA_W'(pending);
            OFF_MODE:    readData = DATA_W'(modeReg);
            OFF_ACTIVE:  readData = {inService, 4'b0000, inService ? id : ID_W'(0)};
            default:     readData = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) io_rdata <= '0;
        else        io_rdata <= rdSel ? readData : '0;
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised and directed bench for interrupt_controller against a cycle-level reference model.
module tb_interrupt_controller;
    localparam logic [15:0] BASE = 16'h1080;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_we;
    logic        io_re;
    logic [7:0]  io_rdata;
    logic        irq_req;
    logic        irq_ack;
    logic [15:0] interrupt_vector;

    interrupt_controller #(
        .NUM_IRQ      (8),
        .BASE_ADDR    (BASE),
        .VECTOR_BASE  (16'h0008),
        .VECTOR_STRIDE(16'h0004)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_in          (irq_in),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .io_we           (io_we),
        .io_re           (io_re),
        .io_rdata        (io_rdata),
        .irq_req         (irq_req),
        .irq_ack         (irq_ack),
        .interrupt_vector(interrupt_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 in service
    logic [7:0]  mEnable, mMode, mPending;
    logic [7:0]  hMeta, hS, hSd;
    int          mPhase;
    int          mId;
    logic        mReq;
    logic [15:0] mVector;
    logic [7:0]  mRdata;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mEnable = '0; mMode = '0; mPending = '0;
        hMeta = '0; hS = '0; hSd = '0;
        mPhase = 0; mId = 0; mReq = 1'b0; mVector = 16'h0008; mRdata = '0;
    endtask

    task automatic modelStep();
        logic [7:0] cand;
        logic [7:0] newPending;
        logic       sel;
        int         off;
        int         newPhase;
        bit         w1c;
        cand = mPending & mEnable;
        sel  = ((io_addr >> 3) == (BASE >> 3));
        off  = int'(io_addr[2:0]);
        mRdata = '0;
        if (sel && io_re) begin
            case (off)
                0: mRdata = mEnable;
                1: mRdata = mPending;
                2: mRdata = mMode;
                3: mRdata = (mPhase == 2) ? (8'h80 | 8'(mId)) : 8'h00;
                default: mRdata = '0;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            w1c = sel && io_we && (off == 1) && io_wdata[i];
            if (!mMode[i])                 newPending[i] = hS[i];
            else if (hS[i] && !hSd[i])     newPending[i] = 1'b1;
            else if (w1c || (mPhase == 1 && irq_ack && mId == i)) newPending[i] = 1'b0;
            else                           newPending[i] = mPending[i];
        end
        newPhase = mPhase;
        if (mPhase == 0) begin
            if (cand != 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (cand[i]) begin mId = i; break; end
                end
                newPhase = 1; mReq = 1'b1;
                mVector = 16'h0008 + 16'(mId * 4);
            end
        end else if (mPhase == 1) begin
            if (irq_ack) begin newPhase = 2; mReq = 1'b0; end
            else if (!cand[mId]) begin newPhase = 0; mReq = 1'b0; end
        end else begin
            if (sel && io_we && off == 4) newPhase = 0;
        end
        mPhase = newPhase;
        mPending = newPending;
        if (sel && io_we && off == 0) mEnable = io_wdata;
        if (sel && io_we && off == 2) mMode = io_wdata;
        hSd = hS; hS = hMeta; hMeta = irq_in;
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        check("irq_req", 16'(irq_req), 16'(mReq));
        check("vector", interrupt_vector, mVector);
        check("rdata", 16'(io_rdata), 16'(mRdata));
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
        io_addr = addr; io_wdata = data; io_we = 1'b1;
        cycle();
        io_we = 1'b0;
    endtask

    task automatic busRead(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        io_addr = addr; io_re = 1'b1;
        cycle();
        io_re = 1'b0;
        check(tag, 16'(io_rdata), 16'(exp));
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq_in = bits;
        cycle();
        irq_in = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!irq_req && n < 16) begin
            cycle();
            n++;
        end
        check(tag, 16'(irq_req), 16'h0001);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #2;
        modelReset();
        check("rst_req", 16'(irq_req), 16'h0000);
        check("rst_vector", interrupt_vector, 16'h0008);
        check("rst_rdata", 16'(io_rdata), 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; io_addr = '0; io_wdata = '0;
        io_we = 1'b0; io_re = 1'b0; irq_ack = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        applyReset();
        busRead("rst_active", BASE + 16'd3, 8'h00);

        // Single edge source: four-edge latency, ack clears pending
        busWrite(BASE + 16'd2, 8'h04);
        busWrite(BASE + 16'd0, 8'h04);
        pulse(8'h04);
        check("t2_edge1", 16'(irq_req), 16'h0000);
        cycle();
        check("t2_edge2", 16'(irq_req), 16'h0000);
        cycle();
        check("t2_edge3", 16'(irq_req), 16'h0000);
        cycle();
        check("t2_edge4", 16'(irq_req), 16'h0001);
        check("t2_vector", interrupt_vector, 16'h0010);
        ack();
        busRead("t2_pending", BASE + 16'd1, 8'h00);
        busRead("t2_active", BASE + 16'd3, 8'h82);
        busWrite(BASE + 16'd4, 8'h5A);
        busRead("t2_eoi", BASE + 16'd3, 8'h00);

        // Priority between simultaneous sources
        busWrite(BASE + 16'd2, 8'h22);
        busWrite(BASE + 16'd0, 8'h22);
        pulse(8'h22);
        cycle(); cycle(); cycle();
        check("t3_req1", 16'(irq_req), 16'h0001);
        check("t3_vec1", interrupt_vector, 16'h000C);
        ack();
        busWrite(BASE + 16'd4, 8'h00);
        cycle();
        check("t3_req2", 16'(irq_req), 16'h0001);
        check("t3_vec2", interrupt_vector, 16'h001C);
        ack();
        busWrite(BASE + 16'd4, 8'h00);

        // Withdraw before ack, then withdraw racing an ack
        busWrite(BASE + 16'd2, 8'h08);
        busWrite(BASE + 16'd0, 8'h08);
        pulse(8'h08);
        waitReq("t4_req");
        check("t4_vector", interrupt_vector, 16'h0014);
        busWrite(BASE + 16'd0, 8'h00);
        cycle();
        check("t4_dropped", 16'(irq_req), 16'h0000);
        busRead("t4_idle", BASE + 16'd3, 8'h00);
        busWrite(BASE + 16'd0, 8'h08);
        waitReq("t4_rereq");
        busWrite(BASE + 16'd0, 8'h00);
        ack();
        busRead("t4_svc", BASE + 16'd3, 8'h83);
        busWrite(BASE + 16'd4, 8'h00);
        busWrite(BASE + 16'd1, 8'h08);

        // Level source held across EOI re-requests one cycle later
        busWrite(BASE + 16'd2, 8'h00);
        busWrite(BASE + 16'd0, 8'h01);
        irq_in = 8'h01;
        waitReq("t5_req");
        check("t5_vector", interrupt_vector, 16'h0008);
        ack();
        busWrite(BASE + 16'd4, 8'h00);
        check("t5_eoi_low", 16'(irq_req), 16'h0000);
        cycle();
        check("t5_rereq", 16'(irq_req), 16'h0001);
        check("t5_vector2", interrupt_vector, 16'h0008);
        irq_in = 8'h00;
        for (int i = 0; i < 6; i++) cycle();
        busWrite(BASE + 16'd0, 8'h00);

        // Bus decode and set-beats-W1C
        busWrite(BASE + 16'd6, 8'hFF);
        busWrite(BASE + 16'd8, 8'hFF);
        busRead("t6_enable", BASE + 16'd0, 8'h00);
        busRead("t6_mode", BASE + 16'd2, 8'h00);
        busRead("t6_off7", BASE + 16'd7, 8'h00);
        busRead("t6_below", BASE - 16'd1, 8'h00);
        busWrite(BASE + 16'd2, 8'h10);
        pulse(8'h10);
        cycle();
        busWrite(BASE + 16'd1, 8'h10);
        busRead("t6_setwins", BASE + 16'd1, 8'h10);
        busWrite(BASE + 16'd1, 8'h10);
        busRead("t6_w1c", BASE + 16'd1, 8'h00);

        // Randomised traffic checked cycle by cycle against the model
        for (int c = 0; c < 2500; c++) begin
            int r;
            if ($urandom_range(0, 5) == 0) irq_in = 8'($urandom);
            irq_ack  = ($urandom_range(0, 3) == 0);
            io_we    = ($urandom_range(0, 2) == 0);
            io_re    = ($urandom_range(0, 1) == 0);
            io_wdata = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 9)      io_addr = BASE - 16'd1;
            else             io_addr = BASE + 16'(r);
            cycle();
        end
        irq_in = '0; irq_ack = 1'b0; io_we = 1'b0; io_re = 1'b0;
        applyReset();

        // Reset while an interrupt is in service
        busWrite(BASE + 16'd2, 8'h04);
        busWrite(BASE + 16'd0, 8'h04);
        pulse(8'h04);
        waitReq("t1_req");
        ack();
        busRead("t1_svc", BASE + 16'd3, 8'h82);
        applyReset();
        busRead("t1_active", BASE + 16'd3, 8'h00);
        busRead("t1_enable", BASE + 16'd0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
